// File: rtl/branch_resolve_ctrl.sv
// Resolves one BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR at a time: capture -> evaluate -> respond.
// Define BRANCH_STATS_EN to add saturating branch / mispredict counters.
module branch_resolve_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [WIDTH-1:0] in_op1,
   input  logic [WIDTH-1:0] in_op2,
   input  logic [2:0]       in_funct3,
   input  logic             in_is_jal,
   input  logic             in_is_jalr,
   input  logic             in_pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [WIDTH-1:0] out_link,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc,
   output logic             err_illegal,
   output logic             err_misalign
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_mispredicts
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // the producer holds its payload stable while valid is high and ready is low.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] pc_q, imm_q, op1_q, op2_q;
   logic [2:0]       funct3_q;
   logic             is_jal_q, is_jalr_q, pred_q;

   logic             taken_q, illegal_q, misalign_q;
   logic [WIDTH-1:0] link_q, rpc_q;

   logic             cond_c, is_jump_c, illegal_c, taken_c, misalign_c;
   logic [WIDTH-1:0] jalr_sum_c, target_c, link_c;

   always_comb begin
      cond_c = 1'b0;
      case (funct3_q)
         3'b000:  cond_c = (op1_q == op2_q);
         3'b001:  cond_c = (op1_q != op2_q);
         3'b100:  cond_c = ($signed(op1_q) <  $signed(op2_q));
         3'b101:  cond_c = ($signed(op1_q) >= $signed(op2_q));
         3'b110:  cond_c = (op1_q <  op2_q);
         3'b111:  cond_c = (op1_q >= op2_q);
         default: cond_c = 1'b0;
      endcase
      is_jump_c  = is_jal_q | is_jalr_q;
      illegal_c  = !is_jump_c && (funct3_q[2:1] == 2'b01);
      taken_c    = is_jump_c | cond_c;
      jalr_sum_c = op1_q + imm_q;
      // JALR takes priority when both jump flags are set
      target_c   = is_jalr_q ? {jalr_sum_c[WIDTH-1:1], 1'b0} : (pc_q + imm_q);
      link_c     = pc_q + WIDTH'(4);
      misalign_c = taken_c & target_c[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc_q       <= '0;
         imm_q      <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         funct3_q   <= '0;
         is_jal_q   <= 1'b0;
         is_jalr_q  <= 1'b0;
         pred_q     <= 1'b0;
         taken_q    <= 1'b0;
         illegal_q  <= 1'b0;
         misalign_q <= 1'b0;
         link_q     <= '0;
         rpc_q      <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  pc_q      <= in_pc;
                  imm_q     <= in_imm;
                  op1_q     <= in_op1;
                  op2_q     <= in_op2;
                  funct3_q  <= in_funct3;
                  is_jal_q  <= in_is_jal;
                  is_jalr_q <= in_is_jalr;
                  pred_q    <= in_pred_taken;
                  state     <= S_EVAL;
               end
            end
            S_EVAL: begin
               taken_q    <= taken_c;
               illegal_q  <= illegal_c;
               misalign_q <= misalign_c;
               link_q     <= link_c;
               rpc_q      <= taken_c ? target_c : link_c;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Result fields are gated by RESP so every output reads zero outside a response.
   logic resp;
   assign resp           = (state == S_RESP);
   assign in_ready       = (state == S_IDLE);
   assign out_valid      = resp;
   assign out_taken      = resp & taken_q;
   assign out_link       = resp ? link_q : '0;
   assign redirect_pc    = resp ? rpc_q : '0;
   assign err_illegal    = resp & illegal_q;
   assign err_misalign   = resp & misalign_q;
   assign redirect_valid = resp & (taken_q != pred_q) & !illegal_q & !misalign_q;

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (resp && out_ready && !flush) begin
         if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
         if (redirect_valid && (stat_mispredicts != 32'hFFFF_FFFF))
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized transactions checked against a behavioural model.
module tb_branch_resolve_ctrl;
   localparam int W = 32;

   logic         clk, rst_n, flush;
   logic         in_valid, in_ready;
   logic [W-1:0] in_pc, in_imm, in_op1, in_op2;
   logic [2:0]   in_funct3;
   logic         in_is_jal, in_is_jalr, in_pred_taken;
   logic         out_valid, out_ready, out_taken;
   logic [W-1:0] out_link, redirect_pc;
   logic         redirect_valid, err_illegal, err_misalign;
`ifdef BRANCH_STATS_EN
   logic [31:0]  stat_branches, stat_mispredicts;
`endif

   branch_resolve_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm), .in_op1(in_op1), .in_op2(in_op2),
      .in_funct3(in_funct3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
      .in_pred_taken(in_pred_taken),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_link(out_link), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .err_illegal(err_illegal), .err_misalign(err_misalign)
`ifdef BRANCH_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- vectors and model ----------------
   typedef struct {
      string        name;
      logic [W-1:0] pc, imm, op1, op2;
      logic [2:0]   f3;
      logic         jal, jalr, pred;
      logic         taken;
      logic [W-1:0] link, rpc;
      logic         rv, ill, mis;
   } vec_t;

   vec_t vecs[12];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_br   = 0;
   int   exp_mp   = 0;

   function automatic vec_t mk(string n, logic [W-1:0] pc, logic [W-1:0] imm,
                               logic [W-1:0] op1, logic [W-1:0] op2, logic [2:0] f3,
                               logic jal, logic jalr, logic pred, logic taken,
                               logic [W-1:0] link, logic [W-1:0] rpc,
                               logic rv, logic ill, logic mis);
      vec_t v;
      v.name = n; v.pc = pc; v.imm = imm; v.op1 = op1; v.op2 = op2; v.f3 = f3;
      v.jal = jal; v.jalr = jalr; v.pred = pred; v.taken = taken;
      v.link = link; v.rpc = rpc; v.rv = rv; v.ill = ill; v.mis = mis;
      return v;
   endfunction

   // Reference: direct reading of the branch rules, applied to one instruction.
   function automatic vec_t model(vec_t v);
      vec_t         e = v;
      logic [W-1:0] tgt;
      longint       sa, sb, ua, ub;
      sa = longint'($signed(v.op1));
      sb = longint'($signed(v.op2));
      ua = longint'({32'd0, v.op1});
      ub = longint'({32'd0, v.op2});
      e.ill = 1'b0;
      if (v.jalr) begin
         tgt = v.op1 + v.imm;
         tgt[0] = 1'b0;
         e.taken = 1'b1;
      end else if (v.jal) begin
         tgt = v.pc + v.imm;
         e.taken = 1'b1;
      end else begin
         tgt = v.pc + v.imm;
         case (v.f3)
            3'd0: e.taken = (ua == ub);
            3'd1: e.taken = (ua != ub);
            3'd4: e.taken = (sa < sb);
            3'd5: e.taken = (sa >= sb);
            3'd6: e.taken = (ua < ub);
            3'd7: e.taken = (ua >= ub);
            default: begin e.taken = 1'b0; e.ill = 1'b1; end
         endcase
      end
      e.link = v.pc + 32'd4;
      e.mis  = e.taken && tgt[1];
      e.rpc  = e.taken ? tgt : e.link;
      e.rv   = (e.taken != v.pred) && !e.ill && !e.mis;
      return e;
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic cmp_out(input string tag, input vec_t e);
      chk({tag, " out_valid"}, W'(out_valid), W'(1'b1));
      chk({tag, " taken"}, W'(out_taken), W'(e.taken));
      chk({tag, " link"}, out_link, e.link);
      chk({tag, " redirect_pc"}, redirect_pc, e.rpc);
      chk({tag, " redirect_valid"}, W'(redirect_valid), W'(e.rv));
      chk({tag, " err_illegal"}, W'(err_illegal), W'(e.ill));
      chk({tag, " err_misalign"}, W'(err_misalign), W'(e.mis));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input vec_t v);
      in_pc = v.pc; in_imm = v.imm; in_op1 = v.op1; in_op2 = v.op2;
      in_funct3 = v.f3; in_is_jal = v.jal; in_is_jalr = v.jalr; in_pred_taken = v.pred;
   endtask

   task automatic scramble();
      in_pc = $urandom; in_imm = $urandom; in_op1 = $urandom; in_op2 = $urandom;
      in_funct3 = 3'($urandom_range(0, 7)); in_is_jal = 1'($urandom_range(0, 1));
      in_is_jalr = 1'($urandom_range(0, 1)); in_pred_taken = 1'($urandom_range(0, 1));
   endtask

   task automatic issue(input vec_t v);
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      chk({v.name, " in_ready before accept"}, W'(in_ready), W'(1'b1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble();
   endtask

   // Returns cycles from the accept edge until out_valid is seen (expected 1).
   task automatic wait_resp(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (!out_valid && cyc < 6) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_txn(input vec_t e, input int stall);
      int cyc;
      out_ready = (stall == 0);
      issue(e);
      wait_resp(cyc);
      chk({e.name, " latency"}, W'(cyc), W'(1));
      cmp_out(e.name, e);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({e.name, " stall out_valid"}, W'(out_valid), W'(1'b1));
         chk({e.name, " stall redirect_pc"}, redirect_pc, e.rpc);
      end
      out_ready = 1'b1;
      exp_br++;
      if (e.rv) exp_mp++;
      @(negedge clk);
      chk({e.name, " post out_valid"}, W'(out_valid), W'(1'b0));
      chk({e.name, " post in_ready"}, W'(in_ready), W'(1'b1));
      chk({e.name, " post redirect_valid"}, W'(redirect_valid), W'(1'b0));
   endtask

   function automatic vec_t rand_vec();
      vec_t         v;
      logic [W-1:0] t;
      int           k;
      v.name = "rand";
      v.pc   = $urandom & 32'hFFFF_FFFC;
      t      = W'($urandom_range(0, 4095));
      v.imm  = $urandom_range(0, 1) ? t : -t;
      v.op1  = $urandom;
      case ($urandom_range(0, 3))
         0: v.op2 = v.op1;
         1: v.op2 = v.op1 + 32'd1;
         2: v.op2 = v.op1 ^ 32'h8000_0000;
         default: v.op2 = $urandom;
      endcase
      v.f3 = 3'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      v.jal  = (k == 0) || (k == 2);
      v.jalr = (k == 1) || (k == 2);
      v.pred = 1'($urandom_range(0, 1));
      return model(v);
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int   cyc;
      vec_t r;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_imm = '0; in_op1 = '0; in_op2 = '0; in_funct3 = '0;
      in_is_jal = 1'b0; in_is_jalr = 1'b0; in_pred_taken = 1'b0;

      vecs[0]  = mk("beq",       32'h100, 32'h20, 32'd5, 32'd5, 3'd0, 0, 0, 0,
                   1, 32'h104, 32'h120, 1, 0, 0);
      vecs[1]  = mk("blt",       32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'd4, 0, 0, 0,
                   1, 32'h204, 32'h210, 1, 0, 0);
      vecs[2]  = mk("bltu",      32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'd6, 0, 0, 0,
                   0, 32'h204, 32'h204, 0, 0, 0);
      vecs[3]  = mk("jalr_mis",  32'h40, 32'h2, 32'h1001, 32'd0, 3'd0, 0, 1, 1,
                   1, 32'h44, 32'h1002, 0, 0, 1);
      vecs[4]  = mk("f3_010",    32'h300, 32'h8, 32'd9, 32'd9, 3'd2, 0, 0, 0,
                   0, 32'h304, 32'h304, 0, 1, 0);
      vecs[5]  = mk("bgeu_eq",   32'h400, 32'h40, 32'd7, 32'd7, 3'd7, 0, 0, 1,
                   1, 32'h404, 32'h440, 0, 0, 0);
      vecs[6]  = mk("bne_eq",    32'h500, 32'h100, 32'd3, 32'd3, 3'd1, 0, 0, 1,
                   0, 32'h504, 32'h504, 1, 0, 0);
      vecs[7]  = mk("jal_wrap",  32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0, 3'd3, 1, 0, 0,
                   1, 32'h0, 32'h4, 1, 0, 0);
      vecs[8]  = mk("jal_jalr",  32'h10, 32'h20, 32'h1000, 32'd0, 3'd0, 1, 1, 1,
                   1, 32'h14, 32'h1020, 0, 0, 0);
      vecs[9]  = mk("bge_sign",  32'h600, 32'hFFFF_FFF0, 32'h8000_0000, 32'h7FFF_FFFF, 3'd5, 0, 0, 1,
                   0, 32'h604, 32'h604, 1, 0, 0);
      vecs[10] = mk("beq_mis",   32'h700, 32'h6, 32'd4, 32'd4, 3'd0, 0, 0, 0,
                   1, 32'h704, 32'h706, 0, 0, 1);
      vecs[11] = mk("f3_011",    32'h800, 32'h8, 32'd1, 32'd2, 3'd3, 0, 0, 1,
                   0, 32'h804, 32'h804, 0, 1, 0);

      // reset state
      repeat (3) @(negedge clk);
      chk("reset in_ready", W'(in_ready), W'(1'b1));
      chk("reset out_valid", W'(out_valid), W'(1'b0));
      chk("reset out_taken", W'(out_taken), W'(1'b0));
      chk("reset out_link", out_link, '0);
      chk("reset redirect_valid", W'(redirect_valid), W'(1'b0));
      chk("reset redirect_pc", redirect_pc, '0);
      chk("reset err_illegal", W'(err_illegal), W'(1'b0));
      chk("reset err_misalign", W'(err_misalign), W'(1'b0));
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_txn(vecs[i], 0);

      // backpressure: result held, new requests ignored
      out_ready = 1'b0;
      issue(vecs[0]);
      wait_resp(cyc);
      chk("bp latency", W'(cyc), W'(1));
      cmp_out("bp first", vecs[0]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(vecs[2]);
         in_valid = 1'b1;
         chk("bp out_valid", W'(out_valid), W'(1'b1));
         chk("bp in_ready", W'(in_ready), W'(1'b0));
         chk("bp redirect_pc", redirect_pc, vecs[0].rpc);
         chk("bp link", out_link, vecs[0].link);
         chk("bp redirect_valid", W'(redirect_valid), W'(vecs[0].rv));
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp last out_valid", W'(out_valid), W'(1'b1));
      exp_br++;
      if (vecs[0].rv) exp_mp++;
      @(negedge clk);
      chk("bp release out_valid", W'(out_valid), W'(1'b0));
      chk("bp release in_ready", W'(in_ready), W'(1'b1));
      @(negedge clk);
      chk("bp no stray accept", W'(in_ready), W'(1'b1));

      // flush during EVAL
      issue(vecs[1]);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush eval out_valid", W'(out_valid), W'(1'b0));
      chk("flush eval in_ready", W'(in_ready), W'(1'b1));
      repeat (2) begin
         @(negedge clk);
         chk("flush eval no result", W'(out_valid), W'(1'b0));
      end

      // request presented together with flush is not accepted
      @(negedge clk);
      drive(vecs[0]);
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flush idle in_ready", W'(in_ready), W'(1'b1));
      @(negedge clk);
      chk("flush idle out_valid", W'(out_valid), W'(1'b0));

      // flush and out_ready together in RESP
      out_ready = 1'b0;
      issue(vecs[1]);
      wait_resp(cyc);
      chk("flush resp latency", W'(cyc), W'(1));
      flush = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush resp out_valid", W'(out_valid), W'(1'b0));
      chk("flush resp in_ready", W'(in_ready), W'(1'b1));

      // randomized transactions against the model
      for (int i = 0; i < 150; i++) begin
         r = rand_vec();
         run_txn(r, $urandom_range(0, 2));
      end

`ifdef BRANCH_STATS_EN
      chk("stat_branches", stat_branches, W'(exp_br));
      chk("stat_mispredicts", stat_mispredicts, W'(exp_mp));
`endif

      // asynchronous reset while in RESP
      out_ready = 1'b0;
      issue(vecs[0]);
      wait_resp(cyc);
      chk("rst resp latency", W'(cyc), W'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("rst resp out_valid", W'(out_valid), W'(1'b0));
      chk("rst resp in_ready", W'(in_ready), W'(1'b1));
      chk("rst resp redirect_valid", W'(redirect_valid), W'(1'b0));
      chk("rst resp out_link", out_link, '0);
      exp_br = 0;
      exp_mp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      run_txn(vecs[7], 0);

`ifdef BRANCH_STATS_EN
      chk("stat_branches after reset", stat_branches, W'(exp_br));
      chk("stat_mispredicts after reset", stat_mispredicts, W'(exp_mp));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
